// File: rtl/bdd_sbox_dualrail_ctrl.sv
// bdd_sbox_dualrail_ctrl: precharge/evaluate sequencer and dual-rail result capture for a BDD S-box.
module bdd_sbox_dualrail_ctrl #(
    parameter int N_IN         = 4,
    parameter int N_OUT        = 4,
    parameter int PRE_CYCLES   = 2,
    parameter int EVAL_TIMEOUT = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N_IN-1:0]  in_data,
    output logic [N_IN-1:0]  sbox_sel,
    output logic [N_IN-1:0]  sbox_sel_n,
    output logic             sbox_pre,
    input  logic [N_OUT-1:0] sbox_u,
    input  logic [N_OUT-1:0] sbox_c,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N_OUT-1:0] out_data,
    output logic [1:0]       out_err
);
    localparam int CMAX = (EVAL_TIMEOUT > PRE_CYCLES) ? EVAL_TIMEOUT : PRE_CYCLES;
    localparam int CW   = $clog2(CMAX) + 1;

    typedef enum logic [1:0] {IDLE, PRE, EVAL, DONE} state_t;

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [N_IN-1:0]  r_sel;
    logic [N_IN-1:0]  r_sel_n;
    logic             r_pre;
    logic             r_valid;
    logic [N_OUT-1:0] r_data;
    logic [1:0]       r_err;
    logic [N_OUT-1:0] r_u;
    logic [N_OUT-1:0] r_c;
    logic             w_both;
    logic             w_all;
    logic             w_any;

    // Rail decisions use the registered samples so the async S-box outputs never feed the FSM directly.
    assign w_both = |(r_u & r_c);
    assign w_all  = &(r_u ^ r_c);
    assign w_any  = |{r_u, r_c};

    assign in_ready   = (r_state == IDLE);
    assign sbox_sel   = r_sel;
    assign sbox_sel_n = r_sel_n;
    assign sbox_pre   = r_pre;
    assign out_valid  = r_valid;
    assign out_data   = r_data;
    assign out_err    = r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_sel   <= '0;
            r_sel_n <= '1;
            r_pre   <= 1'b0;
            r_valid <= 1'b0;
            r_data  <= '0;
            r_err   <= 2'b00;
            r_u     <= '0;
            r_c     <= '0;
        end else begin
            r_u <= sbox_u;
            r_c <= sbox_c;
            case (r_state)
                IDLE: if (in_valid) begin
                    r_sel   <= in_data;
                    r_sel_n <= ~in_data;
                    r_cnt   <= CW'(PRE_CYCLES - 1);
                    r_state <= PRE;
                end
                PRE: if (r_cnt == '0) begin
                    if (w_any) begin
                        r_err   <= 2'b11;
                        r_data  <= '0;
                        r_valid <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_pre   <= 1'b1;
                        r_cnt   <= CW'(EVAL_TIMEOUT - 1);
                        r_state <= EVAL;
                    end
                end else begin
                    r_cnt <= r_cnt - CW'(1);
                end
                EVAL: if (w_both || w_all || r_cnt == '0) begin
                    r_err   <= w_both ? 2'b01 : w_all ? 2'b00 : 2'b10;
                    r_data  <= (w_both || w_all) ? r_u : '0;
                    r_pre   <= 1'b0;
                    r_valid <= 1'b1;
                    r_state <= DONE;
                end else begin
                    r_cnt <= r_cnt - CW'(1);
                end
                DONE: if (out_ready) begin
                    r_valid <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
